// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive byte FIFO behind the UART receiver.
// Define UART_RX_FIFO_ERR_EN to store the frame error tag with each byte.
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     enabled,
  input  logic                     flush,
  input  logic                     rx_done,
  input  logic                     rx_err,
  input  logic [7:0]               rx_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic                     rd_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_RX_FIFO_ERR_EN
  localparam int EW = 9;
`else
  localparam int EW = 8;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic          wr_req;
  logic          rd_fire;
  logic          wr_ok;
  logic          drop;

`ifdef UART_RX_FIFO_ERR_EN
  assign wr_req   = rx_done & enabled;
  assign wr_entry = {rx_err, rx_data};
`else
  // errored frames are discarded silently, never counted as overflow
  assign wr_req   = rx_done & enabled & ~rx_err;
  assign wr_entry = rx_data;
`endif

  assign rd_fire = rd_valid & rd_ready;
  assign wr_ok   = wr_req & (~full | rd_fire);
  assign drop    = wr_req & full & ~rd_fire;

  // pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rstN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_ok, rd_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  // storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_ok && !flush && !rstN)
      mem[wr_ptr] <= wr_entry;
  end

  assign head        = mem[rd_ptr];
  assign count       = cnt;
  assign empty       = (cnt == '0);
  assign full        = (cnt == CW'(DEPTH));
  assign almost_full = (cnt >= CW'(AFULL_LEVEL));
  assign rd_valid    = ~empty;
  assign rd_data     = empty ? 8'h00 : head[7:0];
`ifdef UART_RX_FIFO_ERR_EN
  assign rd_err      = ~empty & head[8];
`else
  assign rd_err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo.
// Queue model of the FIFO, directed plan then random traffic.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AFL   = 12;
`ifdef UART_RX_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rstN;
  logic       enabled;
  logic       flush;
  logic       rx_done;
  logic       rx_err;
  logic [7:0] rx_data;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_err;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       overflow;
  logic       ovf_clr;

  uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
    .clk(clk), .rstN(rstN), .enabled(enabled), .flush(flush),
    .rx_done(rx_done), .rx_err(rx_err), .rx_data(rx_data),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_err(rd_err), .count(count), .empty(empty), .full(full),
    .almost_full(almost_full), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [8:0] sb [$];
  int         m_cnt = 0;
  bit         m_ovf = 1'b0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endfunction

  // monitor: every read handshake pops the oldest expected entry
  always @(negedge clk) begin
    if (!rstN && !flush && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected", {31'b0, rd_valid}, 32'd0);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("rd_data", {24'b0, rd_data}, {24'b0, e[7:0]});
        chk("rd_err", {31'b0, rd_err}, {31'b0, e[8]});
      end
    end
  end

  task automatic check_state();
    chk("count", {27'b0, count}, m_cnt);
    chk("empty", {31'b0, empty}, {31'b0, m_cnt == 0});
    chk("full", {31'b0, full}, {31'b0, m_cnt == DEPTH});
    chk("almost_full", {31'b0, almost_full}, {31'b0, m_cnt >= AFL});
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, m_cnt != 0});
    if (m_cnt == 0)
      chk("gated_out", {23'b0, rd_err, rd_data}, 32'd0);
  endtask

  task automatic drive(input logic done, input logic [7:0] d,
                       input logic err, input logic rdy,
                       input logic en, input logic fl,
                       input logic rst, input logic oclr);
    bit rdf, wreq, acc;
    rx_done  = done;
    rx_data  = d;
    rx_err   = err;
    rd_ready = rdy;
    enabled  = en;
    flush    = fl;
    rstN     = rst;
    ovf_clr  = oclr;
    if (rst || fl) begin
      m_cnt = 0;
      m_ovf = 1'b0;
      sb.delete();
    end else begin
      rdf  = (m_cnt > 0) && rdy;
      wreq = done && en && (ERR_EN || !err);
      acc  = wreq && ((m_cnt < DEPTH) || rdf);
      if (acc)
        sb.push_back({ERR_EN ? err : 1'b0, d});
      if (wreq && !acc)
        m_ovf = 1'b1;
      else if (oclr)
        m_ovf = 1'b0;
      m_cnt = m_cnt + int'(acc) - int'(rdf);
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic wr(input logic [7:0] d, input logic rdy);
    drive(1'b1, d, 1'b0, rdy, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++)
      rd();
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();

    wr(8'hA5, 1'b0);
    idle();
    rd();

    for (int i = 0; i < 16; i++)
      wr(8'(i), 1'b0);
    wr(8'hEE, 1'b0);
    for (int i = 0; i < 8; i++)
      rd();
    for (int i = 16; i < 24; i++)
      wr(8'(i), 1'b0);
    wr(8'hEF, 1'b1);
    drive(1'b1, 8'hED, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 5; i++)
      wr(8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 6; i++)
      wr(8'(8'h50 + i), 1'b1);
    drain();
    wr(8'h3C, 1'b0);
    drain();

    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    drain();

    for (int i = 0; i < 7; i++)
      wr(8'(8'h70 + i), 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 7; i++)
      wr(8'(8'h80 + i), 1'b0);
    drive(1'b1, 8'h88, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wr(8'h67, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      int rp;
      logic dn, er, rr, en, fl, rs, oc;
      rp = ((i / 500) % 4) * 30 + 5;
      dn = ($urandom_range(99) < 60);
      er = ($urandom_range(7) == 0);
      rr = ($urandom_range(99) < rp);
      en = ($urandom_range(19) != 0);
      fl = ($urandom_range(299) == 0);
      rs = ($urandom_range(999) == 0);
      oc = ($urandom_range(39) == 0);
      drive(dn, 8'($urandom), er, rr, en, fl, rs, oc);
    end
    drain();
    chk("sb_left", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. Captures each completed frame (`rx_done` pulse with `rx_data`/`rx_err`) into a circular FIFO and presents it to the host/bus side through a first-word-fall-through valid/ready interface. Tracks occupancy and almost-full, and keeps a sticky overflow flag so no byte is lost silently when the consumer stalls.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `AFULL_LEVEL`, 12: `almost_full` asserts when `count` ≥ this value; range 1..DEPTH.

Ports:
- `clk`  in  1  single clock for the block.
- `rstN`  in  1  reset; synchronous, active-high.
- `enabled`  in  1  write enable; frames arriving while low are ignored.
- `flush`  in  1  synchronous clear of contents and flags.
- `rx_done`  in  1  one-cycle pulse from receiver: frame complete.
- `rx_err`  in  1  frame error flag, qualified by `rx_done`.
- `rx_data`  in  8  received byte, qualified by `rx_done`.
- `rd_ready`  in  1  consumer accepts the head entry.
- `rd_valid`  out  1  head entry is available (`!empty`).
- `rd_data`  out  8  head entry byte.
- `rd_err`  out  1  head entry error tag (see Configuration).
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `almost_full`  out  1  `count >= AFULL_LEVEL`.
- `overflow`  out  1  sticky: a frame was dropped because the FIFO was full.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- Storage: `DEPTH` entries; write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits, wrap naturally modulo DEPTH; occupancy tracked in a separate `count` register.
- Write request: `wr_req = rx_done & enabled`. Write accepted when `wr_req & (!full | rd_fire)`. On accept: mem[wr_ptr] ← entry, `wr_ptr` + 1.
- Read: `rd_fire = rd_valid & rd_ready`. On fire: `rd_ptr` + 1. `rd_ready` while empty has no effect.
- Count: +1 on accepted write only, −1 on read only, unchanged for both or neither.
- Full with simultaneous read and write: both performed; count stays DEPTH; no overflow.
- Full, write request, no read: byte dropped, pointers unchanged, `overflow` ← 1.
- `overflow`: set as above; cleared by `ovf_clr`; a set event in the same cycle as `ovf_clr` wins (flag stays 1).
- `flush`: pointers, count and `overflow` return to 0. Any write or read in the same cycle is discarded. Flush has priority over everything except `rstN`.
- `enabled` low does not block reads.

## Timing
- Reset (`rstN` high at a clock edge): `wr_ptr` = `rd_ptr` = 0, `count` = 0, `overflow` = 0. Outputs: `rd_valid` = 0, `empty` = 1, `full` = 0, `almost_full` = 0, `overflow` = 0, `rd_data` and `rd_err` = 0 (gated while empty). Memory contents are not reset.
- Write-to-read latency: a byte written at edge N appears with `rd_valid` = 1 in the cycle after edge N. There is no combinational bypass: a write into an empty FIFO does not raise `rd_valid` in the same cycle.
- `rd_data`/`rd_err` are combinational from mem[`rd_ptr`], forced to 0 when empty. They are stable while `rd_valid` is high and `rd_ready` is low.
- After a read fire at edge N, the next entry is presented in the cycle following edge N. Sustained throughput is one byte per cycle.
- `count`, `empty`, `full`, `almost_full` and `overflow` are all registered or derived from registered state. They update on the same edge as the pointer change.
- Reset or `flush` mid-stream: all state clears on that edge. An `rx_done` pulse in the same cycle is lost.

## Configuration
- Macro `UART_RX_FIFO_ERR_EN`.
- Defined:
  - Entries are 9 bits, {err, data}.
  - Frames with `rx_err` = 1 are stored, and `rd_err` reflects the stored tag.
- Undefined:
  - Entries are 8 bits.
  - Frames with `rx_err` = 1 are discarded: not written and not counted as overflow.
  - `rd_err` is tied to 0.

## Test plan
- Reset then single write: `rx_data`=8'hA5, `rx_done` pulse → next cycle `rd_valid`=1, `rd_data`=8'hA5, `count`=1. With `rd_ready`=1 for one cycle → `empty`=1, `count`=0.
- Fill to wrap (DEPTH=16): write 0x00..0x0F with `rd_ready`=0 → `full`=1, `almost_full`=1 from `count`=12. Drain 8, write 0x10..0x17 → reads return 0x08..0x17 in order.
- Overflow: with FIFO full, write 0xEE without read → `overflow`=1, `count`=16, 0xEE never read. Repeat with `rd_ready`=1 in the same cycle → accepted, `overflow` unchanged. Assert `ovf_clr` → `overflow`=0.
- Simultaneous read and write at `count`=5 → `count` stays 5 and data order is preserved. Write 0x3C while empty → `rd_valid`=0 in that cycle, 1 in the next.
- Error tag: `rx_err`=1 with 0x55. With `UART_RX_FIFO_ERR_EN`: `rd_data`=0x55, `rd_err`=1. Without: `count` stays 0 and `overflow`=0.
- Flush and reset mid-stream: at `count`=7, `flush` with a concurrent `rx_done` → `count`=0, `empty`=1, `overflow`=0. Same sequence with `rstN` → all outputs at reset values. `enabled`=0 with `rx_done` → no write.
